// File: rtl/multi_channel_state_monitor_if.sv
// Control and status bundle for the multi-channel state monitor.
// The monitor attaches through the slave modport; the controlling side uses master.
interface multi_channel_state_monitor_if #(
    parameter int N_CH  = 8,
    parameter int DLY_W = 4,
    parameter int EVT_W = 8
);
    logic              ena;
    logic [N_CH-1:0]   sig_in;
    logic [DLY_W-1:0]  delay_sel;
    logic              mode;
    logic              clr_evt;
    logic [N_CH-1:0]   stable_out;
    logic [N_CH-1:0]   change_pulse;
    logic [N_CH-1:0]   transient;
    logic [EVT_W-1:0]  evt_cnt;
    logic              evt_ovf;
    logic              any_change;

    modport master (
        output ena, sig_in, delay_sel, mode, clr_evt,
        input  stable_out, change_pulse, transient, evt_cnt, evt_ovf, any_change
    );

    modport slave (
        input  ena, sig_in, delay_sel, mode, clr_evt,
        output stable_out, change_pulse, transient, evt_cnt, evt_ovf, any_change
    );
endinterface

// File: rtl/multi_channel_state_monitor.sv
// Per-channel holdoff/debounce filter with a saturating event counter; no backpressure, ena=0 freezes all state.
// Latency from sig_in edge k: holdoff reports after k+1, debounce after k+2+L.
module multi_channel_state_monitor #(
    parameter int N_CH  = 8,
    parameter int DLY_W = 4,
    parameter int SCALE = 10000,
    parameter int CNT_W = 18,
    parameter int EVT_W = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    multi_channel_state_monitor_if.slave   bus
);

    localparam int SCL_W  = $clog2(SCALE + 1);
    localparam int PROD_W = DLY_W + SCL_W + CNT_W;
    localparam int PC_W   = $clog2(N_CH + 1);
    localparam int SUM_W  = EVT_W + PC_W + 1;

    localparam logic [PROD_W-1:0] L_MAX   = PROD_W'({CNT_W{1'b1}});
    localparam logic [SUM_W-1:0]  EVT_MAX = SUM_W'({EVT_W{1'b1}});

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_TRANS = 1'b1
    } state_t;

    logic [N_CH-1:0]  r_sync_q;
    logic [N_CH-1:0]  r_stable;
    logic [N_CH-1:0]  r_pulse;
    logic [N_CH-1:0]  r_cap_mode;
    state_t           r_state [N_CH];
    logic [CNT_W-1:0] r_cnt   [N_CH];
    logic [EVT_W-1:0] r_evt_cnt;
    logic             r_evt_ovf;

    logic [PROD_W-1:0] w_prod;
    logic [CNT_W-1:0]  w_len;
    state_t            w_state_nxt [N_CH];
    logic [CNT_W-1:0]  w_cnt_nxt   [N_CH];
    logic [N_CH-1:0]   w_stable_nxt;
    logic [N_CH-1:0]   w_pulse_nxt;
    logic [N_CH-1:0]   w_cap_mode_nxt;
    logic [N_CH-1:0]   w_pulse_gated;
    logic [N_CH-1:0]   w_trans;
    logic [PC_W-1:0]   w_pc;
    logic [SUM_W-1:0]  w_sum;

    // Full-width product so large delay_sel*SCALE saturates instead of wrapping.
    assign w_prod = PROD_W'(bus.delay_sel) * PROD_W'(SCALE);
    assign w_len  = (w_prod > L_MAX) ? {CNT_W{1'b1}} : w_prod[CNT_W-1:0];

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_state_nxt[i]    = r_state[i];
            w_cnt_nxt[i]      = r_cnt[i];
            w_stable_nxt[i]   = r_stable[i];
            w_pulse_nxt[i]    = 1'b0;
            w_cap_mode_nxt[i] = r_cap_mode[i];
            case (r_state[i])
                ST_IDLE: begin
                    if (r_sync_q[i] != r_stable[i]) begin
                        w_state_nxt[i]    = ST_TRANS;
                        w_cnt_nxt[i]      = w_len;
                        w_cap_mode_nxt[i] = bus.mode;
                        if (!bus.mode) begin
                            w_stable_nxt[i] = r_sync_q[i];
                            w_pulse_nxt[i]  = 1'b1;
                        end
                    end
                end
                ST_TRANS: begin
                    if (!r_cap_mode[i]) begin
                        if (r_cnt[i] == '0) begin
                            w_state_nxt[i] = ST_IDLE;
                        end else begin
                            w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
                        end
                    end else if (r_sync_q[i] == r_stable[i]) begin
                        w_state_nxt[i] = ST_IDLE;
                    end else if (r_cnt[i] == '0) begin
                        w_stable_nxt[i] = r_sync_q[i];
                        w_pulse_nxt[i]  = 1'b1;
                        w_state_nxt[i]  = ST_IDLE;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
                    end
                end
                default: w_state_nxt[i] = ST_IDLE;
            endcase
        end
    end

    // A pulse pending while frozen stays hidden and is shown once ena returns.
    assign w_pulse_gated = r_pulse & {N_CH{bus.ena}};

    always_comb begin
        w_pc    = '0;
        w_trans = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_pc       = w_pc + PC_W'(w_pulse_gated[i]);
            w_trans[i] = (r_state[i] == ST_TRANS);
        end
        w_sum = (bus.clr_evt ? SUM_W'(0) : SUM_W'(r_evt_cnt)) + SUM_W'(w_pc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_q   <= '0;
            r_stable   <= '0;
            r_pulse    <= '0;
            r_cap_mode <= '0;
            r_evt_cnt  <= '0;
            r_evt_ovf  <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                r_state[i] <= ST_IDLE;
                r_cnt[i]   <= '0;
            end
        end else if (bus.ena) begin
            r_sync_q   <= bus.sig_in;
            r_stable   <= w_stable_nxt;
            r_pulse    <= w_pulse_nxt;
            r_cap_mode <= w_cap_mode_nxt;
            for (int i = 0; i < N_CH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
            r_evt_cnt <= (w_sum > EVT_MAX) ? {EVT_W{1'b1}} : w_sum[EVT_W-1:0];
            if (bus.clr_evt) begin
                r_evt_ovf <= 1'b0;
            end else if (w_sum > EVT_MAX) begin
                r_evt_ovf <= 1'b1;
            end
        end
    end

    assign bus.stable_out   = r_stable;
    assign bus.change_pulse = w_pulse_gated;
    assign bus.transient    = w_trans;
    assign bus.evt_cnt      = r_evt_cnt;
    assign bus.evt_ovf      = r_evt_ovf;
    assign bus.any_change   = |w_pulse_gated;

endmodule

// File: tb/tb_multi_channel_state_monitor.sv
// Directed bench: a small-scale monitor for filter/counter behaviour and a
// second instance with a large SCALE to exercise window saturation.
module tb_multi_channel_state_monitor;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    multi_channel_state_monitor_if #(.N_CH(4), .DLY_W(4), .EVT_W(3)) bus_a ();
    multi_channel_state_monitor_if #(.N_CH(4), .DLY_W(4), .EVT_W(3)) bus_s ();

    multi_channel_state_monitor #(
        .N_CH(4), .DLY_W(4), .SCALE(4), .CNT_W(8), .EVT_W(3)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    multi_channel_state_monitor #(
        .N_CH(4), .DLY_W(4), .SCALE(100), .CNT_W(8), .EVT_W(3)
    ) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        int tcnt;
        int pcnt;
        int pat;

        bus_a.ena = 1'b1; bus_a.sig_in = '0; bus_a.delay_sel = '0; bus_a.mode = 1'b0; bus_a.clr_evt = 1'b0;
        bus_s.ena = 1'b1; bus_s.sig_in = '0; bus_s.delay_sel = '0; bus_s.mode = 1'b0; bus_s.clr_evt = 1'b0;
        tick();
        tick();
        check("rst_stable",    32'(bus_a.stable_out),   32'h0);
        check("rst_pulse",     32'(bus_a.change_pulse), 32'h0);
        check("rst_transient", 32'(bus_a.transient),    32'h0);
        check("rst_evt_cnt",   32'(bus_a.evt_cnt),      32'h0);
        check("rst_evt_ovf",   32'(bus_a.evt_ovf),      32'h0);
        rst_n = 1'b1;
        tick();

        // Holdoff on ch0, L = 2*4 = 8
        bus_a.mode = 1'b0; bus_a.delay_sel = 4'd2; bus_a.sig_in[0] = 1'b1;
        tick();
        check("ho_no_pulse_k", 32'(bus_a.change_pulse), 32'h0);
        tcnt = 0; pcnt = 0;
        for (int j = 1; j <= 14; j++) begin
            bus_a.sig_in[0] = (j > 8) ? 1'b1 : ((j % 2) == 0);
            tick();
            if (j == 1) begin
                check("ho_pulse_k1",  32'(bus_a.change_pulse), 32'h1);
                check("ho_any_k1",    32'(bus_a.any_change),   32'h1);
                check("ho_stable_k1", 32'(bus_a.stable_out),   32'h1);
            end
            tcnt += int'(bus_a.transient[0]);
            pcnt += int'(bus_a.change_pulse[0]);
        end
        check("ho_trans_cycles", 32'(tcnt), 32'd9);
        check("ho_pulse_count",  32'(pcnt), 32'd1);
        check("ho_stable_end",   32'(bus_a.stable_out), 32'h1);
        check("ho_evt_cnt",      32'(bus_a.evt_cnt),    32'd1);

        // Debounce glitch on ch1, L = 4
        bus_a.clr_evt = 1'b1;
        tick();
        bus_a.clr_evt = 1'b0;
        check("clr_evt_cnt", 32'(bus_a.evt_cnt), 32'd0);
        bus_a.mode = 1'b1; bus_a.delay_sel = 4'd1;
        tcnt = 0; pcnt = 0;
        for (int j = 0; j <= 12; j++) begin
            bus_a.sig_in[1] = (j < 3);
            tick();
            tcnt += int'(bus_a.transient[1]);
            pcnt += int'(bus_a.change_pulse[1]);
        end
        check("db_glitch_trans",  32'(tcnt), 32'd3);
        check("db_glitch_pulses", 32'(pcnt), 32'd0);
        check("db_glitch_stable", 32'(bus_a.stable_out), 32'h1);
        check("db_glitch_evt",    32'(bus_a.evt_cnt),    32'd0);

        // Debounce accept on ch1: pulse after edge k+6
        pcnt = 0; pat = -1;
        for (int j = 0; j <= 13; j++) begin
            bus_a.sig_in[1] = (j < 10);
            tick();
            if (bus_a.change_pulse[1]) begin
                pcnt++;
                pat = j;
            end
        end
        check("db_accept_edge",   32'(pat),  32'd6);
        check("db_accept_pulses", 32'(pcnt), 32'd1);
        check("db_accept_stable", 32'(bus_a.stable_out), 32'h3);
        check("db_release_trans", 32'(bus_a.transient),  32'h2);
        check("db_accept_evt",    32'(bus_a.evt_cnt),    32'd1);

        // Window entered in debounce must keep debounce despite a live mode change
        bus_a.mode = 1'b0; bus_a.delay_sel = 4'd0;
        tick();
        check("cap_stable_k14", 32'(bus_a.stable_out), 32'h3);
        tick();
        check("cap_pulse_k15", 32'(bus_a.change_pulse), 32'h0);
        tick();
        check("cap_pulse_k16",  32'(bus_a.change_pulse), 32'h2);
        check("cap_stable_k16", 32'(bus_a.stable_out),   32'h1);
        tick();
        check("cap_evt", 32'(bus_a.evt_cnt), 32'd2);

        // Simultaneous edges and counter saturation
        bus_a.clr_evt = 1'b1;
        tick();
        bus_a.clr_evt = 1'b0;
        check("sim_clr", 32'(bus_a.evt_cnt), 32'd0);
        bus_a.sig_in = 4'b1110;
        tick(); tick();
        check("sim1_pulse", 32'(bus_a.change_pulse), 32'hf);
        tick();
        check("sim1_evt", 32'(bus_a.evt_cnt), 32'd4);
        check("sim1_ovf", 32'(bus_a.evt_ovf), 32'd0);
        bus_a.sig_in = 4'b0001;
        tick(); tick();
        check("sim2_pulse", 32'(bus_a.change_pulse), 32'hf);
        tick();
        check("sim2_evt", 32'(bus_a.evt_cnt), 32'd7);
        check("sim2_ovf", 32'(bus_a.evt_ovf), 32'd1);
        bus_a.sig_in = 4'b1110;
        tick(); tick();
        check("sim3_pulse", 32'(bus_a.change_pulse), 32'hf);
        bus_a.clr_evt = 1'b1;
        tick();
        bus_a.clr_evt = 1'b0;
        check("sim3_evt", 32'(bus_a.evt_cnt), 32'd4);
        check("sim3_ovf", 32'(bus_a.evt_ovf), 32'd0);

        // Window saturation: 15*100 clips to 255
        bus_s.mode = 1'b0; bus_s.delay_sel = 4'd15; bus_s.sig_in[2] = 1'b1;
        tcnt = 0; pcnt = 0;
        for (int j = 0; j < 300; j++) begin
            tick();
            tcnt += int'(bus_s.transient[2]);
            pcnt += int'(bus_s.change_pulse[2]);
        end
        check("sat_trans_cycles", 32'(tcnt), 32'd256);
        check("sat_pulses",       32'(pcnt), 32'd1);
        check("sat_evt",          32'(bus_s.evt_cnt), 32'd1);

        // Asynchronous reset mid-window
        bus_a.delay_sel = 4'd3; bus_a.mode = 1'b0; bus_a.sig_in[3] = 1'b0;
        tick(); tick();
        check("pre_rst_pulse",  32'(bus_a.change_pulse), 32'h8);
        check("pre_rst_stable", 32'(bus_a.stable_out),   32'h6);
        tick(); tick();
        check("pre_rst_trans",  32'(bus_a.transient), 32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_stable",   32'(bus_a.stable_out),   32'h0);
        check("arst_trans",    32'(bus_a.transient),    32'h0);
        check("arst_pulse",    32'(bus_a.change_pulse), 32'h0);
        check("arst_any",      32'(bus_a.any_change),   32'h0);
        check("arst_evt",      32'(bus_a.evt_cnt),      32'h0);
        check("arst_ovf",      32'(bus_a.evt_ovf),      32'h0);
        check("arst_sat_stbl", 32'(bus_s.stable_out),   32'h0);
        bus_a.sig_in = '0;
        tick();
        rst_n = 1'b1;
        tick();

        // Freeze for 5 cycles inside a holdoff window, L = 4
        bus_a.delay_sel = 4'd1; bus_a.mode = 1'b0; bus_a.sig_in[0] = 1'b1;
        tick(); tick();
        check("frz_pulse_k1", 32'(bus_a.change_pulse), 32'h1);
        tcnt = int'(bus_a.transient[0]);
        pcnt = 0;
        for (int j = 2; j <= 14; j++) begin
            bus_a.ena = !((j >= 3) && (j <= 7));
            tick();
            tcnt += int'(bus_a.transient[0]);
            pcnt += int'(bus_a.change_pulse[0]);
            if (j == 7) begin
                check("frz_trans_hold",  32'(bus_a.transient),  32'h1);
                check("frz_stable_hold", 32'(bus_a.stable_out), 32'h1);
            end
        end
        check("frz_trans_cycles", 32'(tcnt), 32'd10);
        check("frz_pulses",       32'(pcnt), 32'd0);
        check("frz_evt",          32'(bus_a.evt_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
